oppm_word_encoder: RTL and testbench

//  Parametrised PPM transmit sequencer: accepts WORD_W-bit words over valid/ready,

---
 rtl/oppm_word_encoder.sv | 162 ++++++++++++++++
 tb/tb_oppm_word_encoder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/oppm_word_encoder.sv
// PPM transmit sequencer: splits each accepted word into N-bit symbols (MSB first) and emits
// one pulse per symbol frame. Define OPPM_PREAMBLE_EN to prefix each word with preamble frames.
module oppm_word_encoder #(
  parameter int unsigned L         = 4,
  parameter int unsigned N         = 4,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned GUARD     = 0,
  parameter int unsigned PULSE_LEN = 1,
  parameter int unsigned PRE_LEN   = 2,
  parameter int unsigned PRE_SYM   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              pulse,
  output logic              frame_begin,
  output logic [N-1:0]      cur_symbol,
  output logic              busy,
  output logic              word_done
);

  localparam int unsigned K  = WORD_W / N;
  localparam int unsigned F  = (2 ** N) + GUARD;
  localparam int unsigned TW = (L > 1) ? $clog2(L) : 1;
  localparam int unsigned SW = $clog2(F);
  localparam int unsigned IW = $clog2(K + PRE_LEN + 1);

  if (N == 0 || (WORD_W % N) != 0) begin : g_bad_word_w
    $error("oppm_word_encoder: WORD_W must be a nonzero multiple of N");
  end
  if (L == 0 || PULSE_LEN == 0 || PULSE_LEN > L) begin : g_bad_pulse_len
    $error("oppm_word_encoder: require L >= 1 and 1 <= PULSE_LEN <= L");
  end
  if (PRE_SYM >= (2 ** N)) begin : g_bad_pre_sym
    $error("oppm_word_encoder: PRE_SYM does not fit in N bits");
  end

`ifdef OPPM_PREAMBLE_EN
  typedef enum logic [1:0] {StIdle, StPre, StSym} state_e;
`else
  typedef enum logic [0:0] {StIdle, StSym} state_e;
`endif

  state_e              state_q, state_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [SW-1:0]       slot_q, slot_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [N-1:0]        cur_sym_q, cur_sym_d;
  logic                pulse_q, pulse_d;
  logic                tick_last, frame_last, accept;

  assign tick_last   = (tick_q == TW'(L - 1));
  assign frame_last  = tick_last && (slot_q == SW'(F - 1));
  assign busy        = (state_q != StIdle);
  assign frame_begin = busy && (tick_q == '0) && (slot_q == '0);
  assign word_done   = (state_q == StSym) && frame_last && (idx_q == IW'(K - 1));
  assign data_ready  = !rst && ((state_q == StIdle) || word_done);
  assign accept      = data_valid && data_ready;
  assign cur_symbol  = cur_sym_q;
  assign pulse       = pulse_q;

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    slot_d    = slot_q;
    idx_d     = idx_q;
    word_d    = word_q;
    cur_sym_d = cur_sym_q;

    if (state_q != StIdle) begin
      tick_d = tick_last ? '0 : tick_q + 1'b1;
      if (tick_last) begin
        slot_d = (slot_q == SW'(F - 1)) ? '0 : slot_q + 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
      end
`ifdef OPPM_PREAMBLE_EN
      StPre: begin
        if (frame_last) begin
          if (idx_q == IW'(PRE_LEN - 1)) begin
            state_d   = StSym;
            idx_d     = '0;
            cur_sym_d = word_q[WORD_W-1 -: N];
            word_d    = word_q << N;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`endif
      StSym: begin
        if (frame_last) begin
          if (idx_q == IW'(K - 1)) begin
            state_d   = StIdle;
            idx_d     = '0;
            cur_sym_d = '0;
          end else begin
            idx_d     = idx_q + 1'b1;
            cur_sym_d = word_q[WORD_W-1 -: N];
            word_d    = word_q << N;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A handshake always starts a fresh frame, whether from idle or back-to-back.
    if (accept) begin
      idx_d  = '0;
      tick_d = '0;
      slot_d = '0;
`ifdef OPPM_PREAMBLE_EN
      if (PRE_LEN != 0) begin
        state_d   = StPre;
        cur_sym_d = N'(PRE_SYM);
        word_d    = data_in;
      end else begin
        state_d   = StSym;
        cur_sym_d = data_in[WORD_W-1 -: N];
        word_d    = data_in << N;
      end
`else
      state_d   = StSym;
      cur_sym_d = data_in[WORD_W-1 -: N];
      word_d    = data_in << N;
`endif
    end

    // Pulse is registered from next-state counters so it lines up with the slot it marks.
    // Guard slots never match because cur_sym_d is zero-extended below 2**N.
    pulse_d = (state_d != StIdle) && (slot_d == SW'(cur_sym_d)) && (32'(tick_d) < PULSE_LEN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      tick_q    <= '0;
      slot_q    <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      cur_sym_q <= '0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      slot_q    <= slot_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      cur_sym_q <= cur_sym_d;
      pulse_q   <= pulse_d;
    end
  end

endmodule

// File: tb/tb_oppm_word_encoder.sv
// Directed bench for oppm_word_encoder: default DUT (L=4,N=4,WORD_W=8) plus a GUARD=2,
// PULSE_LEN=4 instance; preamble scenario replaces the word tests when OPPM_PREAMBLE_EN is set.
module tb_oppm_word_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid;
  logic       a_ready, a_pulse, a_fb, a_busy, a_done;
  logic       b_ready, b_pulse, b_fb, b_busy, b_done;
  logic [3:0] a_cur, b_cur;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  oppm_word_encoder #(
    .L(4), .N(4), .WORD_W(8), .GUARD(0), .PULSE_LEN(1), .PRE_LEN(2), .PRE_SYM(5)
  ) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .data_in    (a_data),
    .data_valid (a_valid),
    .data_ready (a_ready),
    .pulse      (a_pulse),
    .frame_begin(a_fb),
    .cur_symbol (a_cur),
    .busy       (a_busy),
    .word_done  (a_done)
  );

  oppm_word_encoder #(
    .L(4), .N(4), .WORD_W(8), .GUARD(2), .PULSE_LEN(4), .PRE_LEN(0), .PRE_SYM(0)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .data_in    (b_data),
    .data_valid (b_valid),
    .data_ready (b_ready),
    .pulse      (b_pulse),
    .frame_begin(b_fb),
    .cur_symbol (b_cur),
    .busy       (b_busy),
    .word_done  (b_done)
  );

  task automatic chk(input string tag, input int cyc, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s @%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Present a word on DUT A; the cycle sampled here is cycle 0 of the transaction.
  task automatic start_a(input logic [7:0] word);
    @(posedge clk); #1;
    a_valid = 1'b1;
    a_data  = word;
    @(negedge clk);
    chk("a_ready_c0", 0, a_ready, 1);
  endtask

  // Check DUT A over cycles from..to of a two-symbol word with hand-computed timing.
  task automatic run_a(input int from, input int to, input int p0, input int p1,
                       input int f0, input int f1, input int done_c,
                       input logic [3:0] s0, input logic [3:0] s1,
                       input bit offer, input logic [7:0] word);
    for (int c = from; c <= to; c++) begin
      @(posedge clk); #1;
      if (c == from) begin
        a_valid = offer;
        a_data  = word;
      end
      if (c == done_c + 1) a_valid = 1'b0;
      @(negedge clk);
      chk("a_pulse", c, a_pulse, (c == p0 || c == p1));
      chk("a_frame_begin", c, a_fb, (c == f0 || c == f1));
      chk("a_busy", c, a_busy, (c <= done_c));
      chk("a_word_done", c, a_done, (c == done_c));
      chk("a_ready", c, a_ready, (c >= done_c));
      chk("a_cur_symbol", c, a_cur, (c < f1) ? s0 : ((c <= done_c) ? s1 : 4'd0));
    end
  endtask

  initial begin
    rst     = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_data  = '0;
    b_data  = '0;

    // 1: reset state and idle behaviour.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_pulse", 0, a_pulse, 0);
    chk("rst_a_fb", 0, a_fb, 0);
    chk("rst_a_busy", 0, a_busy, 0);
    chk("rst_a_done", 0, a_done, 0);
    chk("rst_a_cur", 0, a_cur, 0);
    chk("rst_a_ready", 0, a_ready, 0);
    chk("rst_b_ready", 0, b_ready, 0);
    chk("rst_b_pulse", 0, b_pulse, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_a_ready", 0, a_ready, 1);
    chk("idle_b_ready", 0, b_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_a_pulse", i, a_pulse, 0);
      chk("idle_a_busy", i, a_busy, 0);
      chk("idle_b_pulse", i, b_pulse, 0);
    end

`ifdef OPPM_PREAMBLE_EN
    // 6: two preamble frames of symbol 5, then 3 and A.
    start_a(8'h3A);
    for (int c = 1; c <= 258; c++) begin
      @(posedge clk); #1;
      if (c == 1) a_valid = 1'b0;
      @(negedge clk);
      chk("pre_pulse", c, a_pulse, (c == 21 || c == 85 || c == 141 || c == 233));
      chk("pre_fb", c, a_fb, (c == 1 || c == 65 || c == 129 || c == 193));
      chk("pre_done", c, a_done, (c == 256));
      chk("pre_busy", c, a_busy, (c <= 256));
      chk("pre_cur", c, a_cur, (c < 129) ? 4'd5 : (c < 193) ? 4'd3 : (c <= 256) ? 4'hA : 4'd0);
    end
`else
    // 2: single word 8'h3A.
    start_a(8'h3A);
    run_a(1, 131, 13, 105, 1, 65, 128, 4'd3, 4'hA, 1'b0, 8'h00);

    // 3: back-to-back 8'h3A then 8'h0F offered from cycle 1.
    start_a(8'h3A);
    run_a(1, 128, 13, 105, 1, 65, 128, 4'd3, 4'hA, 1'b1, 8'h0F);
    run_a(129, 260, 129, 253, 129, 193, 256, 4'd0, 4'hF, 1'b0, 8'h00);

    // 5: reset at cycle 50 of a word, then a fresh word with nominal timing.
    start_a(8'h3A);
    run_a(1, 49, 13, 105, 1, 65, 128, 4'd3, 4'hA, 1'b0, 8'h00);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 50, a_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_pulse", 51, a_pulse, 0);
    chk("midrst_fb", 51, a_fb, 0);
    chk("midrst_busy", 51, a_busy, 0);
    chk("midrst_done", 51, a_done, 0);
    chk("midrst_cur", 51, a_cur, 0);
    chk("midrst_ready_after", 51, a_ready, 1);
    start_a(8'hC5);
    run_a(1, 130, 49, 85, 1, 65, 128, 4'hC, 4'd5, 1'b0, 8'h00);
`endif

    // 4: GUARD=2, PULSE_LEN=4, word 8'hF0.
    @(posedge clk); #1;
    b_valid = 1'b1;
    b_data  = 8'hF0;
    @(negedge clk);
    chk("b_ready_c0", 0, b_ready, 1);
    for (int c = 1; c <= 146; c++) begin
      @(posedge clk); #1;
      if (c == 1) b_valid = 1'b0;
      @(negedge clk);
      chk("b_pulse", c, b_pulse, ((c >= 61 && c <= 64) || (c >= 73 && c <= 76)));
      chk("b_fb", c, b_fb, (c == 1 || c == 73));
      chk("b_done", c, b_done, (c == 144));
      chk("b_busy", c, b_busy, (c <= 144));
      chk("b_cur", c, b_cur, (c < 73) ? 4'hF : 4'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
